// File: rtl/center_of_mass_divider.sv
// Per-frame centre-of-mass divider: one shared bit-serial restoring divider computes x/y centres in turn.
// Latency 2*WIDTH+2 cycles start->centerValid (2 for a low-mass frame); start while busy is dropped.
module center_of_mass_divider #(
  parameter int WIDTH    = 32,
  parameter int MIN_MASS = 1,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] xTop,
  input  logic [WIDTH-1:0] yTop,
  input  logic [WIDTH-1:0] colorTotal,
  output logic [9:0]       xCenter,
  output logic [9:0]       yCenter,
  output logic             centerValid,
  output logic             noTarget,
  output logic             busy
);

  localparam int             CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_MASS);
  localparam logic [WIDTH-1:0] XMAX_W = WIDTH'(X_MAX);
  localparam logic [WIDTH-1:0] YMAX_W = WIDTH'(Y_MAX);

  typedef enum logic [2:0] {IDLE, DIV_X, DIV_Y, DONE, SKIP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xtop_q, xtop_d, ytop_q, ytop_d, div_q, div_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, qx_q, qx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [9:0]       xcen_q, xcen_d, ycen_q, ycen_d;
  logic             valid_q, valid_d, notgt_q, notgt_d;

  logic             last_bit, div_bit, ge;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub, quo_next;

  assign last_bit = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (colorTotal < MIN_W) ? SKIP : DIV_X;
      DIV_X:   if (last_bit) state_d = DIV_Y;
      DIV_Y:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      SKIP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One restoring step; the compare is WIDTH+1 bits wide so a remainder with its MSB set cannot overflow.
  always_comb begin
    div_bit   = (state_q == DIV_Y) ? ytop_q[cnt_q] : xtop_q[cnt_q];
    rem_shift = {rem_q, div_bit};
    ge        = (rem_shift >= {1'b0, div_q});
    rem_sub   = rem_shift[WIDTH-1:0] - div_q;
    quo_next  = quo_q;
    quo_next[cnt_q] = ge;
  end

  always_comb begin
    xtop_d  = xtop_q;
    ytop_d  = ytop_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    qx_d    = qx_q;
    cnt_d   = cnt_q;
    xcen_d  = xcen_q;
    ycen_d  = ycen_q;
    notgt_d = notgt_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          xtop_d = xTop;
          ytop_d = yTop;
          div_d  = colorTotal;
          cnt_d  = CNT_MAX;
          rem_d  = '0;
          quo_d  = '0;
        end
      end
      DIV_X, DIV_Y: begin
        rem_d = ge ? rem_sub : rem_shift[WIDTH-1:0];
        quo_d = quo_next;
        cnt_d = cnt_q - CW'(1);
        if (state_q == DIV_X && last_bit) begin
          qx_d  = quo_next;
          rem_d = '0;
          quo_d = '0;
          cnt_d = CNT_MAX;
        end
      end
      DONE: begin
        xcen_d  = (qx_q  > XMAX_W) ? XMAX_W[9:0] : qx_q[9:0];
        ycen_d  = (quo_q > YMAX_W) ? YMAX_W[9:0] : quo_q[9:0];
        notgt_d = 1'b0;
        valid_d = 1'b1;
      end
      SKIP: begin
        notgt_d = 1'b1;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xtop_q  <= '0;
      ytop_q  <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      qx_q    <= '0;
      cnt_q   <= '0;
      xcen_q  <= '0;
      ycen_q  <= '0;
      notgt_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      xtop_q  <= xtop_d;
      ytop_q  <= ytop_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      qx_q    <= qx_d;
      cnt_q   <= cnt_d;
      xcen_q  <= xcen_d;
      ycen_q  <= ycen_d;
      notgt_q <= notgt_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    xCenter     = xcen_q;
    yCenter     = ycen_q;
    noTarget    = notgt_q;
    centerValid = valid_q;
  end

endmodule

// File: tb/tb_center_of_mass_divider.sv
// Bench for center_of_mass_divider: two instances (MIN_MASS 1 and 16) against an arithmetic reference model.
module tb_center_of_mass_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] xTop = '0, yTop = '0, colorTotal = '0;
  logic [9:0]  xc_a, yc_a, xc_b, yc_b;
  logic        cv_a, cv_b, nt_a, nt_b, busy_a, busy_b;

  int          tests = 0;
  int          fails = 0;
  logic [9:0]  mx[2];
  logic [9:0]  my[2];
  logic        mnt[2];

  always #5 clk = ~clk;

  center_of_mass_divider #(.WIDTH(32), .MIN_MASS(1), .X_MAX(639), .Y_MAX(479)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .xTop(xTop), .yTop(yTop), .colorTotal(colorTotal),
    .xCenter(xc_a), .yCenter(yc_a), .centerValid(cv_a), .noTarget(nt_a), .busy(busy_a));

  center_of_mass_divider #(.WIDTH(32), .MIN_MASS(16), .X_MAX(639), .Y_MAX(479)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .xTop(xTop), .yTop(yTop), .colorTotal(colorTotal),
    .xCenter(xc_b), .yCenter(yc_b), .centerValid(cv_b), .noTarget(nt_b), .busy(busy_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with clamping; low-mass frames keep the previous centre.
  function automatic logic predict(input int s, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] c);
    logic [31:0] qx, qy, mm;
    mm = (s == 1) ? 32'd16 : 32'd1;
    if (c < mm) begin
      mnt[s] = 1'b1;
      return 1'b1;
    end
    qx = x / c;
    qy = y / c;
    mx[s]  = (qx > 32'd639) ? 10'd639 : qx[9:0];
    my[s]  = (qy > 32'd479) ? 10'd479 : qy[9:0];
    mnt[s] = 1'b0;
    return 1'b0;
  endfunction

  // Enters and leaves on a falling edge so a following call lands in the first IDLE cycle.
  task automatic frame(input int s, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] c, input string tag);
    int   lat;
    bit   busy_ok;
    logic skip, cv, bz;
    skip = predict(s, x, y, c);
    xTop = x; yTop = y; colorTotal = c;
    if (s == 1) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    xTop = $urandom; yTop = $urandom; colorTotal = $urandom;
    lat = -1; busy_ok = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      cv = (s == 1) ? cv_b : cv_a;
      bz = (s == 1) ? busy_b : busy_a;
      if (cv) begin
        lat = k - 1;
        break;
      end
      if (!bz) busy_ok = 1'b0;
    end
    check({tag, ".seen"}, 32'(lat >= 0), 32'd1);
    if (skip) check({tag, ".skiplat"}, 32'(lat == 1 || lat == 2), 32'd1);
    else      check({tag, ".lat"}, 32'(lat), 32'd65);
    check({tag, ".x"},  32'((s == 1) ? xc_b : xc_a), 32'(mx[s]));
    check({tag, ".y"},  32'((s == 1) ? yc_b : yc_a), 32'(my[s]));
    check({tag, ".nt"}, 32'((s == 1) ? nt_b : nt_a), 32'(mnt[s]));
    check({tag, ".busy_at_valid"}, 32'((s == 1) ? busy_b : busy_a), 32'd0);
    check({tag, ".busy_during"}, 32'(busy_ok), 32'd1);
  endtask

  initial begin
    int          pulses, lat;
    bit          busy_done;
    logic [9:0]  gx, gy;
    logic        gnt, dummy;
    logic [31:0] c, x, y;

    mx[0] = '0; my[0] = '0; mnt[0] = 1'b1;
    mx[1] = '0; my[1] = '0; mnt[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst.x", 32'(xc_a), 32'd0);
    check("rst.y", 32'(yc_a), 32'd0);
    check("rst.nt", 32'(nt_a), 32'd1);
    check("rst.cv", 32'(cv_a), 32'd0);
    check("rst.busy", 32'(busy_a), 32'd0);
    check("rst.b_nt", 32'(nt_b), 32'd1);

    frame(0, 32'd6400, 32'd4800, 32'd20, "basic");
    frame(0, 32'd99, 32'd0, 32'd10, "trunc");
    frame(0, 32'hFFFFFFFF, 32'd0, 32'd1, "satx");
    frame(0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000001, "bigdiv");
    frame(0, 32'd200000, 32'd900000, 32'd100, "saty");
    frame(0, 32'd6400, 32'd4800, 32'd20, "basic2");
    frame(0, 32'd1234, 32'd5678, 32'd0, "skip0");
    frame(1, 32'd6400, 32'd4800, 32'd20, "b_basic");
    frame(1, 32'd900, 32'd700, 32'd15, "b_skip15");
    frame(1, 32'd1600, 32'd3200, 32'd16, "b_edge16");

    // Second start 10 cycles into a division must be dropped.
    repeat (2) @(negedge clk);
    dummy = predict(0, 32'd3000, 32'd2000, 32'd10);
    xTop = 32'd3000; yTop = 32'd2000; colorTotal = 32'd10; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    pulses = 0; lat = -1; busy_done = 1'b0; gx = '0; gy = '0; gnt = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 10) begin
        xTop = 32'd500; yTop = 32'd400; colorTotal = 32'd5; start_a = 1'b1;
      end else begin
        start_a = 1'b0;
      end
      if (k == 65) busy_done = busy_a;
      if (cv_a) begin
        pulses++;
        if (lat < 0) begin
          lat = k - 1; gx = xc_a; gy = yc_a; gnt = nt_a;
        end
      end
    end
    check("drop.pulses", 32'(pulses), 32'd1);
    check("drop.lat", 32'(lat), 32'd65);
    check("drop.x", 32'(gx), 32'(mx[0]));
    check("drop.y", 32'(gy), 32'(my[0]));
    check("drop.nt", 32'(gnt), 32'(mnt[0]));
    check("drop.busy_in_done", 32'(busy_done), 32'd1);

    frame(0, 32'd64000, 32'd48000, 32'd200, "b2b_1");
    frame(0, 32'd7000, 32'd3500, 32'd35, "b2b_2");

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       c = 32'd0;
        1:       c = 32'($urandom_range(1, 15));
        2:       c = 32'($urandom_range(16, 5000));
        default: c = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        x = c * 32'($urandom_range(0, 700));
        y = c * 32'($urandom_range(0, 520));
      end else begin
        x = $urandom;
        y = $urandom;
      end
      frame((i % 3 == 2) ? 1 : 0, x, y, c, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a division aborts it silently.
    @(negedge clk);
    xTop = 32'd6400; yTop = 32'd4800; colorTotal = 32'd20; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    mx[0] = '0; my[0] = '0; mnt[0] = 1'b1;
    mx[1] = '0; my[1] = '0; mnt[1] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (cv_a) pulses++;
    end
    check("rstmid.pulses", 32'(pulses), 32'd0);
    check("rstmid.x", 32'(xc_a), 32'd0);
    check("rstmid.y", 32'(yc_a), 32'd0);
    check("rstmid.nt", 32'(nt_a), 32'd1);
    check("rstmid.busy", 32'(busy_a), 32'd0);
    frame(0, 32'd6400, 32'd4800, 32'd20, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
